muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
//  Sits beside the single-cycle ALU and executes MIPS MULT/MULTU/DIV/DIVU iteratively.
//  Also services MTHI/MTLO writes.
//  The control unit stalls the pipeline while busy=1.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH bits each; iterations per op = WIDTH
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      request new op; sampled only when busy=0
//  op            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a             in   WIDTH  multiplicand / dividend (rs)
//  b             in   WIDTH  multiplier / divisor (rt)
//  hi_we, lo_we  in   1      MTHI / MTLO write strobes
//  wdata         in   WIDTH  data for hi_we / lo_we
//  busy          out  1      op in progress
//  done          out  1      one-cycle pulse: hi/lo hold new result
//  div_by_zero   out  1      last DIV/DIVU had b==0; held until next accepted start
//  hi, lo        out  WIDTH  result registers; hold value between ops
// BEHAVIOUR
//  Reset (async, any time, including mid-op):
//   - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
//   - In-flight op is discarded.
//  States: IDLE -> CALC (WIDTH cycles, counter WIDTH-1..0) -> FIX (1 cycle) -> IDLE.
//  Accept: posedge with start=1 and busy=0 (edge E0):
//   - latch op; latch |a|, |b| for signed ops, else raw a, b; latch result signs.
//   - busy=1 from E0.
//  CALC:
//   - multiply: radix-2 shift-add into a 2*WIDTH accumulator.
//   - divide: restoring shift-subtract; one bit per cycle.
//  FIX edge (E0+WIDTH+1):
//   - apply sign correction; write hi/lo; busy->0 and done->1 on this same edge.
//   - done clears on the next edge.
//   - Total latency WIDTH+1 edges from accept to result visible.
//  Back-to-back: start while done=1 is accepted (busy=0 then).
//  start while busy=1 is ignored; no queueing.
//  Sign rules:
//   - MULT: 2*WIDTH two's-complement product; hi = upper half, lo = lower half.
//   - DIV: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
//   - DIV of MIN by -1: lo = MIN, hi = 0 (wraps, no flag).
//   - MULTU/DIVU: no sign processing.
//  Divide by zero (b==0, DIV or DIVU):
//   - Same latency as a normal divide.
//   - At FIX: lo = all ones, hi = a (raw); div_by_zero = 1.
//  div_by_zero is cleared on every accepted start.
//  MTHI/MTLO: hi_we/lo_we write wdata at posedge only when busy=0 and no start is accepted.
//   - Writes during busy, or in the same cycle as an accepted start, are dropped.
//   - hi_we and lo_we together write both registers.
//  hi/lo change only at FIX, on an MTHI/MTLO write, or on reset.
// TESTING (WIDTH=32)
//  1. MULT a=FFFFFFFD(-3), b=7
//     -> done at accept+33 edges; hi=FFFFFFFF, lo=FFFFFFEB; busy high exactly 33 cycles.
//  2. MULTU a=b=FFFFFFFF
//     -> hi=FFFFFFFE, lo=00000001.
//  3. DIV a=FFFFFFF9(-7), b=2
//     -> lo=FFFFFFFD, hi=FFFFFFFF.
//     Then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  4. DIVU a=64, b=0
//     -> lo=FFFFFFFF, hi=00000064, div_by_zero=1.
//     Next MULTU accepted -> div_by_zero=0 on its accept edge.
//  5. Inputs and writes during busy:
//     - start MULTU 5*6; pulse start (op DIV) and hi_we (wdata=AA) at cycle 10
//       -> both ignored; result hi=0, lo=1E.
//     - then hi_we with wdata=AA while idle -> hi=AA.
//  6. Reset and back-to-back:
//     - assert rst_n=0 mid-CALC (cycle 12), asynchronously
//       -> busy, done, hi, lo drop to 0 immediately; no done pulse after release.
//     - back-to-back start on the done cycle -> accepted; second result correct.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and MTHI/MTLO writes.
// One result bit per cycle: WIDTH CALC cycles followed by one sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand conditioning for a newly accepted op
  logic             in_div, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    in_div    = op[1];
    in_signed = ~op[0];
    a_neg     = in_signed & a[WIDTH-1];
    b_neg     = in_signed & b[WIDTH-1];
    a_abs     = a_neg ? (~a + WIDTH'(1)) : a;
    b_abs     = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // One iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [AW-1:0]    mul_step, div_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
    div_step  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Sign correction applied on the FIX cycle
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_lo_q ? (~acc_q + AW'(1)) : acc_q;
    quo_fix  = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CALC;
          cnt_d      = CW'(WIDTH - 1);
          is_div_d   = in_div;
          opb_d      = b_abs;
          acc_d      = {{WIDTH{1'b0}}, a_abs};
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = a_neg;
          dbz_pend_d = in_div & (b == '0);
          dbz_d      = 1'b0;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        if (is_div_q) begin
          // A zero divisor leaves |a| as remainder, so the signed fix restores raw a in hi
          lo_d = dbz_pend_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[AW-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle plus directed literal cases.
module tb_muldiv_unit;

  logic        clk, rst_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one op, straight from the MIPS definitions
  function automatic void compute(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    longint      ps;
    logic [63:0] pu;
    dz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'd0: begin
        ps = longint'($signed(x)) * longint'($signed(y));
        pu = 64'(ps);
        rh = pu[63:32];
        rl = pu[31:0];
      end
      2'd1: begin
        pu = {32'd0, x} * {32'd0, y};
        rh = pu[63:32];
        rl = pu[31:0];
      end
      2'd2: begin
        if (y == 32'd0) begin
          rl = 32'hFFFFFFFF; rh = x; dz = 1'b1;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          rl = 32'h80000000; rh = 32'd0;
        end else begin
          rl = 32'($signed(x) / $signed(y));
          rh = 32'($signed(x) % $signed(y));
        end
      end
      default: begin
        if (y == 32'd0) begin
          rl = 32'hFFFFFFFF; rh = x; dz = 1'b1;
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
    endcase
  endfunction

  // Reference model: results appear WIDTH+1 edges after acceptance
  logic        m_busy, m_done, m_dbz, p_dz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = '0; m_lo = '0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_hi = p_hi; m_lo = p_lo; m_dbz = p_dz;
        end
      end else if (start) begin
        compute(op, a, b, p_hi, p_lo, p_dz);
        m_busy = 1'b1; m_cnt = 33; m_dbz = 1'b0;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic dz_after);
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    dz_after = div_by_zero;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, bc;
    logic dz, seen;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    #1 rst_n = 1'b1;

    // 1: MULT -3 * 7 with latency and busy-width pins
    @(negedge clk); #1;
    start = 1'b1; op = 2'd0; a = 32'hFFFFFFFD; b = 32'd7;
    @(negedge clk);
    bc = busy ? 1 : 0;
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
    chk("t1_latency", 32'(n), 32'd33);
    chk("t1_busy_cycles", 32'(bc), 32'd33);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFEB);

    // 2: MULTU max * max
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, dz);
    wait_done(n);
    chk("t2_hi", hi, 32'hFFFFFFFE);
    chk("t2_lo", lo, 32'h00000001);

    // 3: signed divide and MIN / -1 wrap
    issue(2'd2, 32'hFFFFFFF9, 32'd2, dz);
    wait_done(n);
    chk("t3_lo", lo, 32'hFFFFFFFD);
    chk("t3_hi", hi, 32'hFFFFFFFF);
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, dz);
    wait_done(n);
    chk("t3_min_lo", lo, 32'h80000000);
    chk("t3_min_hi", hi, 32'h00000000);

    // 4: DIVU by zero, flag cleared on the next accept
    issue(2'd3, 32'd100, 32'd0, dz);
    wait_done(n);
    chk("t4_latency", 32'(n), 32'd33);
    chk("t4_lo", lo, 32'hFFFFFFFF);
    chk("t4_hi", hi, 32'h00000064);
    chk("t4_dbz", 32'(div_by_zero), 32'd1);
    issue(2'd1, 32'd3, 32'd4, dz);
    chk("t4_dbz_cleared", 32'(dz), 32'd0);
    wait_done(n);

    // 5: start and MTHI during busy are dropped; MTHI when idle lands
    issue(2'd1, 32'd5, 32'd6, dz);
    repeat (8) @(negedge clk);
    #1 start = 1'b1; op = 2'd2; hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    #1 start = 1'b0; hi_we = 1'b0;
    wait_done(n);
    chk("t5_hi", hi, 32'h0);
    chk("t5_lo", lo, 32'h1E);
    @(negedge clk); #1 hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    chk("t5_mthi", hi, 32'hAA);
    #1 hi_we = 1'b0;

    // 6: asynchronous reset mid-CALC, then back-to-back ops
    issue(2'd1, 32'd1234, 32'd5678, dz);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_hi", hi, 32'd0);
    chk("t6_rst_lo", lo, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done;
    end
    chk("t6_no_done_after_reset", 32'(seen), 32'd0);
    issue(2'd0, 32'hFFFFFFFF, 32'd2, dz);
    wait_done(n);
    chk("t6_first_hi", hi, 32'hFFFFFFFF);
    chk("t6_first_lo", lo, 32'hFFFFFFFE);
    #1 start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    chk("t6_b2b_accepted", 32'(busy), 32'd1);
    #1 start = 1'b0;
    wait_done(n);
    chk("t6_b2b_lo", lo, 32'd14);
    chk("t6_b2b_hi", hi, 32'd2);

    // Random traffic: starts, ops, corner operands and MTHI/MTLO strobes
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
    end
    @(negedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
